mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 23 ++
 rtl/mult_div_core.sv | 68 ++++++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the iterative multiply/divide unit
//   st_e       : FSM states (IDLE, MUL, DIV, DONE)
//   op_e       : operation latched by the datapath core (OP_MUL, OP_DIV)
//   DEF_WIDTH  : default operand/result width
//   CNT_W      : iteration counter width for DEF_WIDTH
package mult_div_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } st_e;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_e;

endpackage

// File: rtl/mult_div_core.sv
// rtl/mult_div_core.sv - per-iteration unsigned shift-add / restoring-divide datapath
//   clk   in   rising-edge clock
//   clr   in   asynchronous active-high reset
//   load  in   capture operands and operation, clear the accumulator high half
//   step  in   perform one iteration (one product or quotient bit)
//   op    in   operation captured on load
//   abs_a in   |A| (multiplicand / dividend)
//   abs_b in   |B| (multiplier / divisor)
//   acc   out  2*WIDTH accumulator: product, or {remainder, quotient}
module mult_div_core
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic               step,
   input  op_e                op,
   input  logic [WIDTH-1:0]   abs_a,
   input  logic [WIDTH-1:0]   abs_b,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   m;        // multiplicand or divisor
   op_e                op_q;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_step;

   always_comb begin
      // Multiply: low half holds the multiplier, consumed LSB first while the
      // partial sum (with carry) shifts down into the vacated bits.
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
      // Divide: remainder shifted left with the next dividend bit appended.
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, m};
      if (op_q == OP_MUL)
         acc_step = {sum, acc[WIDTH-1:1]};
      else if (!diff[WIDTH])
         acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         // Restore: a borrow means the shifted remainder was below the
         // divisor, so bit WIDTH of rem_sh is known to be zero here.
         acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         m    <= '0;
         op_q <= OP_MUL;
         acc  <= '0;
      end else if (load) begin
         op_q <= op;
         if (op == OP_MUL) begin
            m   <= abs_a;
            acc <= {{WIDTH{1'b0}}, abs_b};
         end else begin
            m   <= abs_b;
            acc <= {{WIDTH{1'b0}}, abs_a};
         end
      end else if (step) begin
         acc <= acc_step;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide unit with one-cycle ready strobe
//   clk            in   rising-edge clock
//   clr            in   asynchronous active-high reset
//   data_operandA  in   signed dividend / multiplicand, sampled on the start edge
//   data_operandB  in   signed divisor / multiplier, sampled on the start edge
//   ctrl_MULT      in   start signed multiply (wins over ctrl_DIV)
//   ctrl_DIV       in   start signed divide
//   data_result    out  low WIDTH bits of product, or truncated quotient
//   data_exception out  overflow or divide-by-zero
//   data_resultRDY out  one-cycle strobe, result/exception valid
// Optional: MULT_DIV_EARLY_DIV0_EN finishes a divide by zero one cycle after start.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int CW = $clog2(WIDTH + 1);

   st_e                state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic               sign_q, div0_q;
   logic               load, step, fin, div_done;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] acc, prod_s;
   logic [WIDTH-1:0]   quo, quo_s, fin_res;
   logic               mul_exc, fin_exc;
   op_e                op_start;

   assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign op_start = ctrl_MULT ? OP_MUL : OP_DIV;

`ifdef MULT_DIV_EARLY_DIV0_EN
   assign div_done = (cnt == '0) || div0_q;
`else
   assign div_done = (cnt == '0);
`endif

   mult_div_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .clr   (clr),
      .load  (load),
      .step  (step),
      .op    (op_start),
      .abs_a (abs_a),
      .abs_b (abs_b),
      .acc   (acc)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
         // A new start abandons whatever is in flight.
         load    = 1'b1;
         cnt_n   = CW'(WIDTH);
         state_n = ctrl_MULT ? MUL : DIV;
      end else begin
         case (state)
            MUL: begin
               if (cnt == '0) begin
                  fin     = 1'b1;
                  state_n = DONE;
               end else begin
                  step  = 1'b1;
                  cnt_n = cnt - CW'(1);
               end
            end
            DIV: begin
               if (div_done) begin
                  fin     = 1'b1;
                  state_n = DONE;
               end else begin
                  step  = 1'b1;
                  cnt_n = cnt - CW'(1);
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Sign fix-up and exception detection on the finished accumulator.
   always_comb begin
      prod_s  = sign_q ? -acc : acc;
      // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
      mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
      quo     = acc[WIDTH-1:0];
      quo_s   = sign_q ? -quo : quo;
      if (state == MUL) begin
         fin_res = prod_s[WIDTH-1:0];
         fin_exc = mul_exc;
      end else if (div0_q) begin
         fin_res = '0;
         fin_exc = 1'b1;
      end else begin
         fin_res = quo_s;
         // Only MIN / -1 yields a positive quotient of 2^(WIDTH-1).
         fin_exc = !sign_q && quo[WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt            <= '0;
         sign_q         <= 1'b0;
         div0_q         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         cnt            <= cnt_n;
         data_resultRDY <= fin;
         if (load) begin
            sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_q <= (data_operandB == '0);
         end
         if (fin) begin
            data_result    <= fin_res;
            data_exception <= fin_exc;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

`ifdef MULT_DIV_EARLY_DIV0_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   mult_div_unit dut (
      .clk            (clk),
      .clr            (clr),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model using native 64-bit signed arithmetic.
   task automatic model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e);
      longint p;
      int     ai, bi;
      ai = a;
      bi = b;
      if (mul) begin
         p = longint'(ai) * longint'(bi);
         r = p[31:0];
         e = (p != longint'(signed'(p[31:0])));
      end else if (bi == 0) begin
         r = 32'h0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && bi == -1) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         r = ai / bi;
         e = 1'b0;
      end
   endtask

   // Issue a one-cycle start pulse; any pending expectation is an aborted op.
   task automatic start(input bit mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic e);
      exp_t x;
      @(negedge clk);
      sb.delete();
      x.res = r;
      x.exc = e;
      x.cyc = cyc + 1 + ((!mul && b == 32'h0) ? DIV0_LAT : 33);
      sb.push_back(x);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = mul;
      ctrl_DIV      = !mul;
      @(negedge clk);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic start_m(input bit mul, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        e;
      model(mul, a, b, r, e);
      start(mul, a, b, r, e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         chk("timeout", 64'(sb.size()), 64'h0);
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!clr && data_resultRDY) begin
         if (sb.size() == 0) begin
            chk("spurious_rdy", 64'h1, 64'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("result", 64'(data_result), 64'(mon_e.res));
            chk("exception", 64'(data_exception), 64'(mon_e.exc));
            chk("latency", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_result", 64'(data_result), 64'h0);
      chk("rst_exc", 64'(data_exception), 64'h0);
      chk("rst_rdy", 64'(data_resultRDY), 64'h0);
      clr = 1'b0;
      repeat (2) @(negedge clk);

      start(1'b1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
      wait_idle();
      start(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
      wait_idle();
      start(1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      wait_idle();
      start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      wait_idle();
      start(1'b0, 32'd100, 32'd0, 32'h0, 1'b1);
      wait_idle();
      start(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         start_m(1'b1, $urandom, (i < 3) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom);
         wait_idle();
         start_m(1'b0, $urandom, (i < 3) ? 32'($urandom_range(1, 50)) : $urandom);
         wait_idle();
      end

      // Abort: the multiply must not strobe, only the divide.
      start(1'b1, 32'd5, 32'd5, 32'd25, 1'b0);
      repeat (8) @(negedge clk);
      start(1'b0, 32'd9, 32'd3, 32'd3, 1'b0);
      wait_idle();

      // Asynchronous clear mid-multiply.
      start(1'b1, 32'd5, 32'd7, 32'd35, 1'b0);
      repeat (18) @(negedge clk);
      clr = 1'b1;
      #1;
      sb.delete();
      chk("clr_result", 64'(data_result), 64'h0);
      chk("clr_exc", 64'(data_exception), 64'h0);
      chk("clr_rdy", 64'(data_resultRDY), 64'h0);
      @(negedge clk);
      clr = 1'b0;
      repeat (40) @(negedge clk);
      start(1'b1, 32'd2, 32'd3, 32'd6, 1'b0);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

endmodule
